// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller for the stopwatch timebase.
// One shared tick prescaler produces the cnt_en enable for the BCD time
// counters, and a free-running scan prescaler produces scan_en for the
// 7-segment digit mux. All outputs are registered, and reset is synchronous
// and active-low.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_hold,
    output logic [1:0] state,
    output logic       scan_en
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int SDIV = CLK_HZ / SCAN_HZ;
    localparam int DW   = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int SW   = (SDIV > 1) ? $clog2(SDIV) : 1;

    localparam logic [DW-1:0] PRESC_MAX = DW'(DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SDIV - 1);

    // Both dividers must be exact and at least 2, otherwise the enables
    // would drift from the nominal rates or degenerate into a constant high.
    generate
        if ((DIV * TICK_HZ != CLK_HZ) || (SDIV * SCAN_HZ != CLK_HZ) ||
            (DIV < 2) || (SDIV < 2)) begin : g_bad_params
            $error("stopwatch_ctrl: CLK_HZ must be an exact multiple (>=2) of TICK_HZ and SCAN_HZ");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    state_t        st;
    logic [DW-1:0] presc;
    logic [SW-1:0] scan_cnt;

    assign state = st;

    // Control FSM plus tick prescaler. The tick decision looks only at the
    // pre-edge state, so a tick landing on a pause edge is still issued.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and every
        // register here uses non-blocking assignment so all of them see the
        // same pre-edge values; a blocking write would leak the new state
        // into the prescaler decision within the same edge.
        if (!rst_n) begin
            st       <= S_IDLE;
            presc    <= '0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;

            if (st == S_RUN || st == S_LAP) begin
                if (presc == PRESC_MAX) begin
                    presc  <= '0;
                    cnt_en <= 1'b1;
                end else begin
                    presc <= presc + DW'(1);
                end
            end

            // start_stop has priority; a simultaneous lap_reset is dropped.
            case (st)
                S_IDLE: begin
                    if (start_stop) begin
                        st <= S_RUN;
                    end else if (lap_reset) begin
                        cnt_clr <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        st       <= S_PAUSE;
                        lap_hold <= 1'b0;
                    end else if (lap_reset) begin
                        st       <= S_LAP;
                        lap_hold <= 1'b1;
                    end
                end
                S_LAP: begin
                    if (start_stop) begin
                        st       <= S_PAUSE;
                        lap_hold <= 1'b0;
                    end else if (lap_reset) begin
                        st       <= S_RUN;
                        lap_hold <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        st <= S_RUN;
                    end else if (lap_reset) begin
                        st      <= S_IDLE;
                        cnt_clr <= 1'b1;
                        presc   <= '0;
                    end
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running scan prescaler, independent of the FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_en  <= 1'b0;
        end else begin
            scan_en <= (scan_cnt == SCAN_MAX);
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

endmodule
